// File: rtl/chess_pkg.sv
// Shared definitions for the chess board store: piece codes,
// controller state encoding and square addressing helpers.
package chess_pkg;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] B_PAWN   = 4'd1;
  localparam logic [3:0] B_KNIGHT = 4'd2;
  localparam logic [3:0] B_BISHOP = 4'd3;
  localparam logic [3:0] B_ROOK   = 4'd4;
  localparam logic [3:0] B_QUEEN  = 4'd5;
  localparam logic [3:0] B_KING   = 4'd6;
  localparam logic [3:0] W_PAWN   = 4'd7;
  localparam logic [3:0] W_KNIGHT = 4'd8;
  localparam logic [3:0] W_BISHOP = 4'd9;
  localparam logic [3:0] W_ROOK   = 4'd10;
  localparam logic [3:0] W_QUEEN  = 4'd11;
  localparam logic [3:0] W_KING   = 4'd12;

  // white code = black code + this offset
  localparam logic [3:0] COLOR_OFS = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MV_RD,
    S_MV_WR,
    S_MV_CLR,
    S_DONE
  } state_t;

  function automatic int unsigned sq_addr(
    input int unsigned x,
    input int unsigned y,
    input int unsigned dim
  );
    return y * dim + x;
  endfunction

  function automatic logic coord_ok(
    input int unsigned c,
    input int unsigned dim
  );
    return c < dim;
  endfunction

endpackage

// File: rtl/chess_init_rom.sv
// Combinational initial-board table: square address -> piece code.
// Ports: i_addr (square address), o_piece (code loaded at init).
module chess_init_rom
  import chess_pkg::*;
#(
  parameter int unsigned BOARD_DIM  = 8,
  parameter int unsigned PIECE_W    = 4,
  parameter int unsigned INIT_CHESS = 1,
  parameter int unsigned AW         = 6
) (
  input  logic [AW-1:0]      i_addr,
  output logic [PIECE_W-1:0] o_piece
);

  int unsigned w_row;
  int unsigned w_col;
  logic [3:0]  w_back;

  assign w_row = 32'(i_addr) / BOARD_DIM;
  assign w_col = 32'(i_addr) % BOARD_DIM;

  // back-rank layout, black codes
  always_comb begin
    w_back = EMPTY;
    case (w_col)
      0, 7:    w_back = B_ROOK;
      1, 6:    w_back = B_KNIGHT;
      2, 5:    w_back = B_BISHOP;
      3:       w_back = B_QUEEN;
      4:       w_back = B_KING;
      default: w_back = EMPTY;
    endcase
  end

  always_comb begin
    o_piece = '0;
    if (INIT_CHESS != 0 && BOARD_DIM == 8) begin
      if (w_row == 0)
        o_piece = PIECE_W'(w_back);
      else if (w_row == 1)
        o_piece = PIECE_W'(B_PAWN);
      else if (w_row == 6)
        o_piece = PIECE_W'(W_PAWN);
      else if (w_row == 7)
        o_piece = PIECE_W'(w_back + COLOR_OFS);
    end
  end

endmodule

// File: rtl/board_store.sv
// Board-state memory: NUM_RD registered read ports, atomic moves
// and self-initialisation. Ports: clk/reset, init_req, move_req,
// src/dst coords, rd_x/rd_y -> rd_data, busy, done, move results.
module board_store
  import chess_pkg::*;
#(
  parameter int unsigned BOARD_DIM  = 8,
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned PIECE_W    = 4,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned INIT_CHESS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init_req,
  input  logic                        move_req,
  input  logic [COORD_W-1:0]          src_x,
  input  logic [COORD_W-1:0]          src_y,
  input  logic [COORD_W-1:0]          dst_x,
  input  logic [COORD_W-1:0]          dst_y,
  input  logic [NUM_RD*COORD_W-1:0]   rd_x,
  input  logic [NUM_RD*COORD_W-1:0]   rd_y,
  output logic [NUM_RD*PIECE_W-1:0]   rd_data,
  output logic                        busy,
  output logic                        done,
  output logic [PIECE_W-1:0]          moved_piece,
  output logic [PIECE_W-1:0]          captured_piece,
  output logic                        move_err
);

  localparam int unsigned DEPTH = BOARD_DIM * BOARD_DIM;
  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]      r_addr;
  logic [COORD_W-1:0] r_sx, r_sy, r_dx, r_dy;
  logic [PIECE_W-1:0] r_mem [DEPTH];
  logic [PIECE_W-1:0] r_moved;
  logic [PIECE_W-1:0] r_captured;
  logic               r_err;

  logic [NUM_RD*PIECE_W-1:0] r_rd_data;
  logic [PIECE_W-1:0]        w_rd_val [NUM_RD];

  logic               w_src_ok, w_dst_ok;
  logic [AW-1:0]      w_src_a, w_dst_a;
  logic [PIECE_W-1:0] w_src_piece, w_dst_piece;
  logic               w_same, w_bad;
  logic [PIECE_W-1:0] w_rom;

  logic               w_we;
  logic [AW-1:0]      w_waddr;
  logic [PIECE_W-1:0] w_wdata;

  chess_init_rom #(
    .BOARD_DIM (BOARD_DIM),
    .PIECE_W   (PIECE_W),
    .INIT_CHESS(INIT_CHESS),
    .AW        (AW)
  ) u_rom (
    .i_addr (r_addr),
    .o_piece(w_rom)
  );

  assign w_src_ok =
    coord_ok(32'(r_sx), BOARD_DIM) &&
    coord_ok(32'(r_sy), BOARD_DIM);
  assign w_dst_ok =
    coord_ok(32'(r_dx), BOARD_DIM) &&
    coord_ok(32'(r_dy), BOARD_DIM);

  assign w_src_a =
    AW'(sq_addr(32'(r_sx), 32'(r_sy), BOARD_DIM));
  assign w_dst_a =
    AW'(sq_addr(32'(r_dx), 32'(r_dy), BOARD_DIM));

  assign w_src_piece = w_src_ok ? r_mem[w_src_a] : '0;
  assign w_dst_piece = w_dst_ok ? r_mem[w_dst_a] : '0;

  assign w_same = (r_sx == r_dx) && (r_sy == r_dy);
  assign w_bad  = !w_src_ok || !w_dst_ok ||
                  (w_src_piece == '0);

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (init_req)
          w_next = S_INIT;
        else if (move_req)
          w_next = S_MV_RD;
      end
      S_INIT: begin
        busy    = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_addr;
        w_wdata = w_rom;
        if (r_addr == AW'(DEPTH - 1))
          w_next = S_DONE;
      end
      S_MV_RD: begin
        busy = 1'b1;
        // rejected and null moves skip both writes
        if (w_bad || w_same)
          w_next = S_DONE;
        else
          w_next = S_MV_WR;
      end
      S_MV_WR: begin
        busy    = 1'b1;
        w_we    = 1'b1;
        w_waddr = w_dst_a;
        w_wdata = r_moved;
        w_next  = S_MV_CLR;
      end
      S_MV_CLR: begin
        busy    = 1'b1;
        w_we    = 1'b1;
        w_waddr = w_src_a;
        w_wdata = '0;
        w_next  = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_addr     <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_moved    <= '0;
      r_captured <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && init_req)
        r_addr <= '0;
      else if (r_state == S_INIT)
        r_addr <= r_addr + 1'b1;
      if (r_state == S_IDLE && !init_req && move_req) begin
        r_sx <= src_x;
        r_sy <= src_y;
        r_dx <= dst_x;
        r_dy <= dst_y;
      end
      if (r_state == S_MV_RD) begin
        r_moved    <= w_src_piece;
        r_captured <= (w_same && !w_bad) ? '0 : w_dst_piece;
        r_err      <= w_bad;
      end
    end
  end

  // single write port; a reset cycle drops any pending write
  always_ff @(posedge clk) begin
    if (!reset && w_we)
      r_mem[w_waddr] <= w_wdata;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [COORD_W-1:0] w_x, w_y;
    logic               w_ok;
    logic [AW-1:0]      w_a;
    assign w_x  = rd_x[g*COORD_W +: COORD_W];
    assign w_y  = rd_y[g*COORD_W +: COORD_W];
    assign w_ok = coord_ok(32'(w_x), BOARD_DIM) &&
                  coord_ok(32'(w_y), BOARD_DIM);
    assign w_a  =
      AW'(sq_addr(32'(w_x), 32'(w_y), BOARD_DIM));
    assign w_rd_val[g] = w_ok ? r_mem[w_a] : '0;
  end

  // registered from pre-write memory: read-before-write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        r_rd_data[i*PIECE_W +: PIECE_W] <= w_rd_val[i];
    end
  end

  assign rd_data        = r_rd_data;
  assign moved_piece    = r_moved;
  assign captured_piece = r_captured;
  assign move_err       = r_err;

endmodule
